// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the controller state encoding and the default operand width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 32'sd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor slice: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, through a
// single full-subtractor slice. Result and borrow-out are held between runs.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] diff_r;
    logic [WIDTH-1:0] res_shift_s;
    logic             br_r;
    logic             bout_r;
    logic             d_s;
    logic             br_next_s;
    logic             last_bit_s;

    full_subtractor u_slice (
        .x    (a_sh_r[0]),
        .y    (b_sh_r[0]),
        .bin  (br_r),
        .d    (d_s),
        .bout (br_next_s)
    );

    // Counter tops out at WIDTH-1 inside RUN, so it can never wrap there.
    assign last_bit_s  = (cnt_r == CNT_W'(WIDTH - 1));
    // New difference bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
    assign res_shift_s = WIDTH'({d_s, res_r} >> 1'b1);

    assign diff = diff_r;
    assign bout = bout_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        case (state_r)
            ST_IDLE: ready = 1'b1;
            ST_RUN:  ready = 1'b0;
            ST_DONE: done  = 1'b1;
            default: begin
                ready = 1'b0;
                done  = 1'b0;
            end
        endcase
    end

    // Operand capture, serial datapath and result holding registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            a_sh_r <= {WIDTH{1'b0}};
            b_sh_r <= {WIDTH{1'b0}};
            res_r  <= {WIDTH{1'b0}};
            br_r   <= 1'b0;
            diff_r <= {WIDTH{1'b0}};
            bout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_r <= a;
                        b_sh_r <= b;
                        br_r   <= bin;
                        cnt_r  <= {CNT_W{1'b0}};
                        res_r  <= {WIDTH{1'b0}};
                    end
                end
                ST_RUN: begin
                    a_sh_r <= a_sh_r >> 1'b1;
                    b_sh_r <= b_sh_r >> 1'b1;
                    br_r   <= br_next_s;
                    res_r  <= res_shift_s;
                    if (last_bit_s) begin
                        diff_r <= res_shift_s;
                        bout_r <= br_next_s;
                    end else begin
                        cnt_r  <= cnt_r + CNT_W'(1'b1);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a cycle model predicts ready/done
// and a scoreboard queue holds the expected {bout,diff} of every accepted start.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         bin   = 1'b0;
    logic         ready;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    logic [W:0] sb[$];
    int         m_state  = 0;
    int         m_cnt    = 0;
    logic       rst_seen = 1'b1;
    logic [W:0] m_res    = '0;
    bit         mon_en   = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    endfunction

    // Cycle model of the controller; pushes expected results on accepted starts.
    always @(posedge clk) begin
        rst_seen <= !rst_n;
        if (!rst_n) begin
            m_state <= 0;
            m_cnt   <= 0;
            sb.delete();
        end else begin
            case (m_state)
                0: if (start) begin
                    m_state <= 1;
                    m_cnt   <= 0;
                    sb.push_back(ref_sub(a, b, bin));
                end
                1: if (m_cnt == W - 1) m_state <= 2;
                   else m_cnt <= m_cnt + 1;
                default: m_state <= 0;
            endcase
        end
    end

    // Monitor: handshake vs model, scoreboard pop on done, result hold otherwise.
    always @(negedge clk) begin
        logic [W:0] exp_v;
        if (mon_en) begin
            if (rst_seen) m_res = '0;
            checks++;
            if (ready !== ((m_state == 0) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL ready_model: ready=%b want %b at %0t", ready, (m_state == 0), $time);
            end
            checks++;
            if (done !== ((m_state == 2) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL done_model: done=%b want %b at %0t", done, (m_state == 2), $time);
            end
            if (done === 1'b1) begin
                done_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: done with no pending operation at %0t", $time);
                end else begin
                    exp_v = sb.pop_front();
                    if ({bout, diff} !== exp_v) begin
                        errors++;
                        $display("FAIL scoreboard: {bout,diff}=%h want %h at %0t", {bout, diff}, exp_v, $time);
                    end
                    m_res = exp_v;
                end
            end else begin
                checks++;
                if ({bout, diff} !== m_res) begin
                    errors++;
                    $display("FAIL result_hold: {bout,diff}=%h want %h at %0t", {bout, diff}, m_res, $time);
                end
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbi);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL run_op_ready: ready=%b after %0d cycles, want 1", ready, n);
        end
        a = ta; b = tb_v; bin = tbi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output logic [W:0] res, output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) break;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: done=%b after %0d cycles, want 1", done, lat);
        end
        res = {bout, diff};
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: %b want 1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: %b want 0", done); end
        checks++; if (diff !== 4'h0) begin errors++; $display("FAIL reset_diff: %h want 0", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout: %b want 0", bout); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W:0] res;
        int lat;
        run_op(4'd9, 4'd3, 1'b0);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready_drop: %b want 0", ready); end
        wait_done(res, lat);
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL basic_latency: %0d want %0d", lat, W + 1); end
        checks++; if (res !== 5'h06) begin errors++; $display("FAIL basic_result: %h want 06", res); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back: %b want 1", ready); end
    endtask

    task automatic test_corners();
        logic [W-1:0] ta[3]  = '{4'd3, 4'd0, 4'd15};
        logic [W-1:0] tbv[3] = '{4'd9, 4'd0, 4'd15};
        logic         tbi[3] = '{1'b0, 1'b1, 1'b1};
        logic [W:0]   ex[3]  = '{5'h1A, 5'h1F, 5'h1F};
        logic [W:0]   res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tbv[i], tbi[i]);
            wait_done(res, lat);
            checks++;
            if (res !== ex[i]) begin errors++; $display("FAIL corner_%0d: %h want %h", i, res, ex[i]); end
        end
    endtask

    task automatic test_interference();
        logic [W:0] res;
        int lat, d0;
        d0 = done_cnt;
        run_op(4'd12, 4'd5, 1'b1);
        for (int i = 0; i < W - 1; i++) begin
            a = W'($urandom_range(15, 0));
            b = W'($urandom_range(15, 0));
            bin = 1'($urandom_range(1, 0));
            start = (i % 2 == 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_done(res, lat);
        checks++; if (res !== 5'h06) begin errors++; $display("FAIL interference_result: %h want 06", res); end
        repeat (8) @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL interference_count: %0d dones want 1", done_cnt - d0); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        logic [W:0] res;
        int lat, d0;
        run_op(4'd10, 4'd2, 1'b0);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: %b want 1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: %b want 0", done); end
        checks++; if ({bout, diff} !== 5'h00) begin errors++; $display("FAIL midrst_result: %h want 00", {bout, diff}); end
        repeat (8) @(negedge clk);
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL midrst_no_done: %0d dones want 0", done_cnt - d0); end
        @(posedge clk); #1;
        run_op(4'd7, 4'd2, 1'b0);
        wait_done(res, lat);
        checks++; if (res !== 5'h05) begin errors++; $display("FAIL midrst_after: %h want 05", res); end
    endtask

    task automatic test_back_to_back();
        int d0, prev, cyc;
        d0 = done_cnt; prev = -1; cyc = 0;
        start = 1'b1;
        for (int i = 0; i < 35; i++) begin
            if (i == 20) start = 1'b0;
            a = W'($urandom_range(15, 0));
            b = W'($urandom_range(15, 0));
            bin = 1'($urandom_range(1, 0));
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                if (prev >= 0) begin
                    checks++;
                    if (cyc - prev !== W + 2) begin errors++; $display("FAIL b2b_spacing: %0d want %0d", cyc - prev, W + 2); end
                end
                prev = cyc;
            end
            @(posedge clk); #1;
        end
        checks++; if (done_cnt - d0 !== 4) begin errors++; $display("FAIL b2b_count: %0d dones want 4", done_cnt - d0); end
    endtask

    task automatic test_exhaustive();
        logic [W:0] res;
        int lat, d0;
        logic [8:0] v;
        d0 = done_cnt;
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            run_op(v[3:0], v[7:4], v[8]);
            wait_done(res, lat);
        end
        checks++; if (done_cnt - d0 !== 512) begin errors++; $display("FAIL exhaustive_count: %0d dones want 512", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_interference();
        test_reset_mid_run();
        test_back_to_back();
        test_exhaustive();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits.
REQ-002 Port: clk  input  1  rising-edge clock; the block has one clock.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: start  input  1  request a new subtraction; sampled only while ready=1.
REQ-005 Port: a  input  WIDTH  minuend, unsigned.
REQ-006 Port: b  input  WIDTH  subtrahend, unsigned.
REQ-007 Port: bin  input  1  borrow-in.
REQ-008 Port: ready  output  1  high only in IDLE.
REQ-009 Port: done  output  1  single-cycle pulse; diff and bout are valid in that cycle.
REQ-010 Port: diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH.
REQ-011 Port: bout  output  1  borrow-out; 1 when a < b + bin, unsigned.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE -> RUN when start=1 at a clock edge; on that edge a, b and bin are latched into internal shift registers, the bit counter is cleared and the borrow register is loaded with bin.
REQ-014 In RUN, each clock SHALL process one bit, LSB first, through one full-subtractor slice: d = x ^ y ^ br; br_next = (~x & y) | (~x & br) | (y & br).
REQ-015 The d bit of each RUN cycle SHALL be shifted into the MSB of the result register, so that after WIDTH shifts bit 0 sits at the LSB.
REQ-016 RUN -> DONE on the edge that processes bit WIDTH-1; the counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL NOT wrap inside RUN.
REQ-017 Latency: if start is sampled at edge k, done SHALL be high exactly during the cycle following edge k+WIDTH (WIDTH cycles after start).
REQ-018 DONE -> IDLE unconditionally on the next edge; done=1 only in DONE.
REQ-019 diff and bout SHALL update only on entry to DONE, and SHALL then hold until the next entry to DONE or until reset.
REQ-020 start SHALL be ignored in RUN and DONE; no queuing; operand inputs SHALL be ignored outside the IDLE sampling edge.
REQ-021 A start held high continuously SHALL launch a new operation on each IDLE cycle, i.e. one every WIDTH+2 cycles.
REQ-022 Inputs a, b and bin changing during RUN SHALL NOT affect the result.

Reset
REQ-023 When rst_n=0 at a clock edge: state=IDLE, ready=1, done=0, diff=0, bout=0, and the counter, shift and borrow registers are all 0.
REQ-024 Reset asserted in any state, including mid-RUN, SHALL abort the operation with no done pulse; the first start accepted after reset SHALL behave as in REQ-013.
REQ-025 rst_n SHALL have no asynchronous effect; outputs change only on clk edges.

Structure
REQ-026 The state encoding (IDLE/RUN/DONE as a 2-bit enumerated type) and the default WIDTH constant SHALL live in a shared package, serial_sub_pkg.
REQ-027 The one-bit slice SHALL be a separate combinational sub-module, full_subtractor (ports x, y, bin, d, bout), instantiated exactly once.
REQ-028 All state SHALL be held in flip-flops clocked on clk; there SHALL be no latches and no combinational output loops.

Verification
REQ-029 a=9, b=3, bin=0, start pulsed -> ready drops; done after 4 cycles with diff=6, bout=0; ready=1 on the following cycle.
REQ-030 a=3, b=9, bin=0 -> diff=4'hA, bout=1; a=0, b=0, bin=1 -> diff=4'hF, bout=1; a=15, b=15, bin=1 -> diff=4'hF, bout=1.
REQ-031 Exhaustive check: all 512 combinations of (a, b, bin) with WIDTH=4 -> every done matches the reference model {bout,diff} = {1'b0,a} - {1'b0,b} - bin.
REQ-032 Extra start pulses during RUN, and a/b toggling every cycle during RUN -> exactly one done per accepted start, with the result equal to the latched operands.
REQ-033 rst_n=0 for one cycle at the 2nd RUN cycle -> no done; diff=0, bout=0, ready=1; a subsequent 7-2 operation yields diff=5, bout=0.
REQ-034 start held high for 20 cycles -> done pulses at 6-cycle spacing, each result correct.
